mips_writeback: RTL and testbench
=================================

MIPS_WRITEBACK -- requirements
Module: mips_writeback

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, result-buffer entries (power of 2, min 2).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  (instruction, result) pair from mips_core presented.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 in_instr  input  32  R-type instruction word that produced in_result.
REQ-007 in_result  input  32  ALU result R from mips_core.
REQ-008 wb_stall  input  1  downstream register-file port busy, blocks drain.
REQ-009 wb_en  output  1  one-cycle write strobe.
REQ-010 wb_addr  output  5  destination register (instr[15:11]).
REQ-011 wb_data  output  32  value written.
REQ-012 rd_addr  input  5  shadow register-file read address.
REQ-013 rd_data  output  32  shadow register-file read data, combinational.
REQ-014 retire_count  output  16  writes performed, saturating.
REQ-015 drop_count  output  16  accepted pairs discarded, saturating.
REQ-016 busy  output  1  FIFO non-empty or wb_en high.

Function
REQ-017 Handshake: a pair transfers on a rising edge with in_valid && in_ready; in_ready = !full; a push is never accepted while full, even if a pop occurs that cycle.
REQ-018 Decode: pair is retirable iff opcode instr[31:26]==0, funct instr[5:0] in {0x20,0x21,0x22,0x23,0x24,0x25,0x27,0x00,0x02,0x2B}, and rd instr[15:11]!=0.
REQ-019 Retirable pairs push {rd, in_result} into the FIFO; non-retirable pairs are still accepted, not pushed, and increment drop_count.
REQ-020 FSM states IDLE, DRAIN: IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when the last entry pops and no push occurs that edge.
REQ-021 In DRAIN with wb_stall low: pop one entry per edge; same edge registers wb_en=1, wb_addr, wb_data, writes the shadow register file, and increments retire_count.
REQ-022 wb_stall high: no pop, wb_en=0 next cycle, FIFO contents held; drain resumes the edge after wb_stall falls.
REQ-023 Latency: pair accepted at edge N with empty FIFO and no stall -> wb_en high between edge N+1 and N+2; rd_data shows the value after edge N+1.
REQ-024 Simultaneous push and pop (not full): both occur; occupancy unchanged; order strictly FIFO.
REQ-025 Consecutive writes to the same rd: later write wins; no merging.
REQ-026 Shadow register 0 reads 0 at all times.
REQ-027 Counters stop at 0xFFFF; no wrap.
REQ-028 wb_en is low on any cycle without a pop in the preceding edge.

Reset
REQ-029 Reset clears: FIFO pointers and occupancy, FSM->IDLE, wb_en=0, wb_addr=0, wb_data=0, all 32 shadow registers=0, retire_count=0, drop_count=0.
REQ-030 Reset mid-drain discards pending entries; no wb_en is produced for them; in_ready=1 the cycle after reset.
REQ-031 Reset dominates a concurrent handshake; that pair is lost.

Structure
REQ-032 Shared package mips_pkg holds R-type opcode, funct constants, FSM state encoding, and register-address width.
REQ-033 One sub-module, mips_wb_fifo: parameterised synchronous FIFO (push, pop, full, empty, 37-bit data).

Verification
REQ-034 Single ADD 0x00234820, result 4 -> one wb_en, wb_addr=9, wb_data=4; rd_data(9)=4; retire_count=1.
REQ-035 LW 0x8C090000 and rd=0 instruction 0x00230020 -> no wb_en; drop_count=2; in_ready remains 1.
REQ-036 wb_stall=1, push 5 valid pairs back to back -> 4 accepted, in_ready=0 on the 5th; release stall -> 4 writes in order on consecutive cycles, then 5th accepted.
REQ-037 Continuous stream of 10 valid pairs with no stall -> one write per cycle, order preserved, FIFO never fills.
REQ-038 Reset asserted with 3 entries pending under stall -> no writes after reset; counters 0; rd_data(any)=0.
REQ-039 Two writes to r12 (values 3 then 7) -> rd_data(12)=7 after the second wb_en.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the writeback stage: R-type decode constants, FSM
// encoding and the packed result-buffer entry.
package mips_pkg;

  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = REG_AW + DATA_W;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_retirable(input logic [5:0]        opcode,
                                        input logic [5:0]        funct,
                                        input logic [REG_AW-1:0] rd);
    logic funct_ok;
    case (funct)
      FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB,
      FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLTU: funct_ok = 1'b1;
      default:                                  funct_ok = 1'b0;
    endcase
    return (opcode == OP_RTYPE) && funct_ok && (rd != '0);
  endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// Synchronous result buffer, DEPTH a power of two; pop data is the head entry
// (combinational). Push is ignored when full, pop ignored when empty.
module mips_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign last_o     = (count == {{AW{1'b0}}, 1'b1});
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mips_writeback.sv
// Writeback stage: decodes R-type results, buffers them, retires one per cycle
// into a shadow register file (1-cycle min latency); wb_stall holds the buffer, in_ready=!full.
module mips_writeback
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_instr,
  input  logic [DATA_W-1:0]   in_result,
  input  logic                wb_stall,
  output logic                wb_en,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  input  logic [REG_AW-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [15:0]         retire_count,
  output logic [15:0]         drop_count,
  output logic                busy
);

  wb_state_e         state_q, state_d;
  logic              wb_en_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] shadow_q [32];
  logic [15:0]       retire_cnt_q;
  logic [15:0]       drop_cnt_q;

  logic      accept, retirable, push, pop, drop;
  logic      fifo_full, fifo_empty, fifo_last;
  wb_entry_t push_entry, pop_entry;
  logic      unused_instr_bits;

  assign unused_instr_bits = ^{in_instr[25:16], in_instr[10:6]};

  assign retirable  = is_retirable(in_instr[31:26], in_instr[5:0], in_instr[15:11]);
  assign in_ready   = !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && retirable;
  assign drop       = accept && !retirable;
  assign pop        = (state_q == ST_DRAIN) && !wb_stall && !fifo_empty;
  assign push_entry = {in_instr[15:11], in_result};

  mips_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (pop_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .last_o      (fifo_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (push || !fifo_empty) state_d = ST_DRAIN;
      ST_DRAIN: if (!push && (fifo_empty || (pop && fifo_last))) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wb_en_q <= pop;
      if (pop) begin
        wb_addr_q               <= pop_entry.rd;
        wb_data_q               <= pop_entry.data;
        shadow_q[pop_entry.rd]  <= pop_entry.data;
        if (retire_cnt_q != 16'hFFFF) retire_cnt_q <= retire_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Decode never pushes rd=0, but r0 is forced to zero on read regardless.
  assign rd_data      = (rd_addr == '0) ? '0 : shadow_q[rd_addr];
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_cnt_q;
  assign drop_count   = drop_cnt_q;
  assign busy         = !fifo_empty || wb_en_q;

endmodule

// File: tb/tb_mips_writeback.sv
// Self-checking bench for mips_writeback: scoreboard of expected writes,
// checked by a negedge monitor, plus per-scenario inline checks.
module tb_mips_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_result;
  logic        wb_stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] retire_count;
  logic [15:0] drop_count;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;

  mips_writeback #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_result    (in_result),
    .wb_stall     (wb_stall),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .retire_count (retire_count),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic bit model_retirable(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[15:11] != 5'd0) &&
           (ins[5:0] inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h2B});
  endfunction

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wb_addr, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_addr, wb_data} !== mon_e) begin
          n_fail++;
          $display("FAIL write_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wb_addr, wb_data, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_result = '0; wb_stall = 1'b0; rd_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] res, input int max_wait, output bit ok);
    bit rdy;
    in_valid = 1'b1; in_instr = ins; in_result = res; ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        if (model_retirable(ins)) exp_q.push_back({ins[15:11], res});
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({wb_en, wb_addr, wb_data} !== 38'd0) begin
      n_fail++; $display("FAIL reset_wb: got en=%b addr=%0d data=%h, expected all 0", wb_en, wb_addr, wb_data);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
    n_checks++;
    if (retire_count !== 16'd0 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got retire=%0d drop=%0d, expected 0 0", retire_count, drop_count);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    rd_addr = 5'd9;
    send(32'h00234820, 32'd4, 1, ok);
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: got not accepted, expected accepted"); end
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_latency_early: got wb_en=%b busy=%b, expected 0 1", wb_en, busy);
    end
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'd4) begin
      n_fail++; $display("FAIL single_write: got en=%b addr=%0d data=%0d, expected 1 9 4", wb_en, wb_addr, wb_data);
    end
    n_checks++;
    if (rd_data !== 32'd4) begin n_fail++; $display("FAIL single_rd_data: got %0d, expected 4", rd_data); end
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b0 || retire_count !== 16'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got en=%b retire=%0d busy=%b, expected 0 1 0", wb_en, retire_count, busy);
    end
  endtask

  task automatic test_drop();
    bit ok1, ok2;
    do_reset();
    send(32'h8C090000, 32'h11, 1, ok1);
    send(32'h00230020, 32'h22, 1, ok2);
    in_valid = 1'b0;
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL drop_accept: got ok=%b%b, expected 11", ok1, ok2); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (drop_count !== 16'd2 || retire_count !== 16'd0) begin
      n_fail++; $display("FAIL drop_counts: got drop=%0d retire=%0d, expected 2 0", drop_count, retire_count);
    end
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_flags: got in_ready=%b busy=%b, expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_stall_full();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
    bit ok, rdy, acc5;
    do_reset();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(mk(5'(i + 1), fns[i]), 32'h100 + i, 1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_fill_%0d: got rejected, expected accepted", i); end
    end
    in_valid = 1'b1; in_instr = mk(5'd5, fns[4]); in_result = 32'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || wb_en !== 1'b0) begin
        n_fail++; $display("FAIL stall_full_%0d: got in_ready=%b wb_en=%b, expected 0 0", i, in_ready, wb_en);
      end
    end
    @(posedge clk); #1;
    wb_stall = 1'b0;
    rdy = 1'b0; acc5 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        exp_q.push_back({in_instr[15:11], in_result});
        in_valid = 1'b0; acc5 = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (wb_en !== (c <= 5)) begin
        n_fail++; $display("FAIL stall_drain_c%0d: got wb_en=%b, expected %b", c, wb_en, (c <= 5));
      end
      rdy = in_ready;
    end
    n_checks++;
    if (!acc5 || exp_q.size() != 0 || retire_count !== 16'd5) begin
      n_fail++; $display("FAIL stall_final: got acc5=%b pending=%0d retire=%0d, expected 1 0 5", acc5, exp_q.size(), retire_count);
    end
  endtask

  task automatic test_stream();
    logic [5:0]  fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h2B};
    logic [31:0] vals [10];
    do_reset();
    for (int i = 0; i < 10; i++) vals[i] = $urandom;
    in_valid = 1'b1; in_instr = mk(5'd1, fns[0]); in_result = vals[0];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 10) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d: got 0, expected 1", i); end
      end
      if (i >= 2) begin
        n_checks++;
        if (wb_en !== 1'b1) begin n_fail++; $display("FAIL stream_rate_%0d: got wb_en=0, expected 1", i); end
      end
      @(posedge clk); #1;
      if (i < 10) begin
        exp_q.push_back({in_instr[15:11], in_result});
        if (i < 9) begin
          in_instr = mk(5'(i + 2), fns[i + 1]); in_result = vals[i + 1];
        end else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b0 || retire_count !== 16'd10 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stream_end: got en=%b retire=%0d pending=%0d, expected 0 10 0", wb_en, retire_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    do_reset();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(5'(i + 20), 6'h21), 32'hA0 + i, 1, ok);
    in_valid = 1'b1; in_instr = mk(5'd30, 6'h20); in_result = 32'hDEAD;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; wb_stall = 1'b0;
    exp_q.delete();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, expected 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (wb_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_quiet_%0d: got wb_en=%b busy=%b, expected 0 0", c, wb_en, busy);
      end
    end
    n_checks++;
    if (retire_count !== 16'd0 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_counts: got retire=%0d drop=%0d, expected 0 0", retire_count, drop_count);
    end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a); #1;
      if (rd_data !== 32'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rstmid_regs: got %0d nonzero registers, expected 0", bad); end
  endtask

  task automatic test_same_rd();
    bit ok1, ok2;
    do_reset();
    rd_addr = 5'd12;
    send(32'h00006021, 32'd3, 1, ok1);
    send(32'h00006021, 32'd7, 1, ok2);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'd3) begin n_fail++; $display("FAIL same_rd_first: got %0d, expected 3", rd_data); end
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'd7 || retire_count !== 16'd2) begin
      n_fail++; $display("FAIL same_rd_second: got data=%0d retire=%0d, expected 7 2", rd_data, retire_count);
    end
    rd_addr = 5'd0; #1;
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL r0_zero: got %h, expected 0", rd_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_stall_full();
    test_stream();
    test_reset_mid();
    test_same_rd();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
